// File: rtl/sigencode_z_multi.sv
// rtl/sigencode_z_multi.sv - multi-polynomial signature z encoder, two read/write lanes of COEFF_PER_WORD coefficients
package sigencode_z_pkg;
   localparam int ABR_MEM_ADDR_WIDTH = 15;

   typedef enum logic [1:0] {
      RW_IDLE  = 2'd0,
      RW_READ  = 2'd1,
      RW_WRITE = 2'd2
   } mem_rw_e;

   typedef struct packed {
      mem_rw_e                       rd_wr_en;
      logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
   } mem_if_t;

   typedef struct packed {
      mem_rw_e                       rd_wr_en;
      logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
   } sig_mem_if_t;
endpackage

module sigencode_z_multi
   import sigencode_z_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = ABR_MEM_ADDR_WIDTH,
   parameter int REG_SIZE       = 24,
   parameter int MAX_GAMMA1     = 19,
   parameter int MAX_POLY       = 7,
   parameter int COEFF_PER_WORD = 4
)(
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        zeroize,
   input  logic                                        sigencode_z_enable,
   input  logic [MEM_ADDR_WIDTH-1:0]                   src_base_addr,
   input  logic [MEM_ADDR_WIDTH-1:0]                   dest_base_addr,
   input  logic [2:0]                                  num_poly,
   input  logic                                        gamma1_mode,
   output mem_if_t                                     mem_a_rd_req,
   output mem_if_t                                     mem_b_rd_req,
   input  logic [COEFF_PER_WORD-1:0][REG_SIZE-1:0]     mem_a_rd_data,
   input  logic [COEFF_PER_WORD-1:0][REG_SIZE-1:0]     mem_b_rd_data,
   output sig_mem_if_t                                 sigmem_a_wr_req,
   output sig_mem_if_t                                 sigmem_b_wr_req,
   output logic [COEFF_PER_WORD-1:0][MAX_GAMMA1:0]     sigmem_a_wr_data,
   output logic [COEFF_PER_WORD-1:0][MAX_GAMMA1:0]     sigmem_b_wr_data,
   output logic                                        sigencode_z_busy,
   output logic                                        sigencode_z_done,
   output logic                                        range_err
);
   localparam int RD_PER_POLY = 256 / (2 * COEFF_PER_WORD);
   localparam int CNT_W       = $clog2(MAX_POLY * RD_PER_POLY);
   localparam logic [REG_SIZE:0] Q = (REG_SIZE+1)'(8380417);

   typedef logic [MEM_ADDR_WIDTH-1:0]               addr_t;
   typedef logic [COEFF_PER_WORD-1:0][MAX_GAMMA1:0] lanes_t;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   state_e           state_q, state_d;
   addr_t            src_q, src_d, dest_q, dest_d, wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0] last_q, last_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic             gamma_q, gamma_d, rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
   logic             drain_q, drain_d, err_q, err_d;
   lanes_t           wr_a_q, wr_a_d, wr_b_q, wr_b_d;
   lanes_t           enc_a, enc_b;
   logic [2*COEFF_PER_WORD-1:0] err_vec;
   logic             legal;
   addr_t            rd_addr;

   // Returns {out_of_range, encoded}; centred value G - c with negatives folded via q.
   function automatic logic [MAX_GAMMA1+1:0] encode(input logic [REG_SIZE-1:0] c, input logic mode);
      logic [REG_SIZE:0] g, cc, v;
      g  = mode ? ((REG_SIZE+1)'(1) << MAX_GAMMA1) : ((REG_SIZE+1)'(1) << (MAX_GAMMA1 - 2));
      cc = {1'b0, c};
      if (cc <= g)                  v = g - cc;
      else if (cc < Q && cc > Q - g) v = g + (Q - cc);
      else                           return {1'b1, {(MAX_GAMMA1+1){1'b0}}};
      return {1'b0, (MAX_GAMMA1+1)'(v)};
   endfunction

   for (genvar i = 0; i < COEFF_PER_WORD; i++) begin : g_lane
      logic [MAX_GAMMA1+1:0] res_a, res_b;
      assign res_a          = encode(mem_a_rd_data[i], gamma_q);
      assign res_b          = encode(mem_b_rd_data[i], gamma_q);
      assign enc_a[i]       = res_a[MAX_GAMMA1:0];
      assign enc_b[i]       = res_b[MAX_GAMMA1:0];
      assign err_vec[2*i]   = res_a[MAX_GAMMA1+1];
      assign err_vec[2*i+1] = res_b[MAX_GAMMA1+1];
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dest_d    = dest_q;
      last_d    = last_q;
      gamma_d   = gamma_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      wr_addr_d = wr_addr_q;
      drain_d   = drain_q;
      err_d     = err_q;
      rd_vld_d  = (state_q == ST_RUN);
      wr_vld_d  = rd_vld_q;
      wr_a_d    = '0;
      wr_b_d    = '0;
      legal     = (num_poly != 3'd0) && (int'(num_poly) <= MAX_POLY);

      if (rd_vld_q) begin
         wr_a_d    = enc_a;
         wr_b_d    = enc_b;
         wr_addr_d = dest_q + addr_t'({wr_cnt_q, 1'b0});
         wr_cnt_d  = wr_cnt_q + CNT_W'(1);
         if (|err_vec) err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (sigencode_z_enable) begin
               src_d    = src_base_addr;
               dest_d   = dest_base_addr;
               gamma_d  = gamma1_mode;
               last_d   = CNT_W'(int'(num_poly) * RD_PER_POLY - 1);
               rd_cnt_d = '0;
               wr_cnt_d = '0;
               err_d    = !legal;
               state_d  = legal ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
            if (rd_cnt_q == last_q) begin
               state_d = ST_DRAIN;
               drain_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (zeroize) begin
         state_d   = ST_IDLE;
         src_d     = '0;
         dest_d    = '0;
         last_d    = '0;
         gamma_d   = 1'b0;
         rd_cnt_d  = '0;
         wr_cnt_d  = '0;
         wr_addr_d = '0;
         drain_d   = 1'b0;
         err_d     = 1'b0;
         rd_vld_d  = 1'b0;
         wr_vld_d  = 1'b0;
         wr_a_d    = '0;
         wr_b_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dest_q    <= '0;
         last_q    <= '0;
         gamma_q   <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         wr_addr_q <= '0;
         drain_q   <= 1'b0;
         err_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_a_q    <= '0;
         wr_b_q    <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dest_q    <= dest_d;
         last_q    <= last_d;
         gamma_q   <= gamma_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         wr_addr_q <= wr_addr_d;
         drain_q   <= drain_d;
         err_q     <= err_d;
         rd_vld_q  <= rd_vld_d;
         wr_vld_q  <= wr_vld_d;
         wr_a_q    <= wr_a_d;
         wr_b_q    <= wr_b_d;
      end
   end

   always_comb begin
      rd_addr         = src_q + addr_t'({rd_cnt_q, 1'b0});
      mem_a_rd_req    = '{rd_wr_en: RW_IDLE, addr: '0};
      mem_b_rd_req    = '{rd_wr_en: RW_IDLE, addr: '0};
      sigmem_a_wr_req = '{rd_wr_en: RW_IDLE, addr: '0};
      sigmem_b_wr_req = '{rd_wr_en: RW_IDLE, addr: '0};
      if (state_q == ST_RUN) begin
         mem_a_rd_req = '{rd_wr_en: RW_READ, addr: (ABR_MEM_ADDR_WIDTH)'(rd_addr)};
         mem_b_rd_req = '{rd_wr_en: RW_READ, addr: (ABR_MEM_ADDR_WIDTH)'(rd_addr + addr_t'(1))};
      end
      if (wr_vld_q) begin
         sigmem_a_wr_req = '{rd_wr_en: RW_WRITE, addr: (ABR_MEM_ADDR_WIDTH)'(wr_addr_q)};
         sigmem_b_wr_req = '{rd_wr_en: RW_WRITE, addr: (ABR_MEM_ADDR_WIDTH)'(wr_addr_q + addr_t'(1))};
      end
   end

   // Data registers are only loaded on data cycles, so they already read 0 when idle.
   assign sigmem_a_wr_data = wr_a_q;
   assign sigmem_b_wr_data = wr_b_q;
   assign sigencode_z_busy = (state_q != ST_IDLE);
   assign sigencode_z_done = (state_q == ST_DONE);
   assign range_err        = err_q;
endmodule

// File: tb/tb_sigencode_z_multi.sv
// tb/tb_sigencode_z_multi.sv - randomized self-checking bench for sigencode_z_multi
module tb_sigencode_z_multi;
   import sigencode_z_pkg::*;

   localparam int AW    = 15;
   localparam int DEPTH = 32768;
   localparam int Q     = 8380417;

   logic clk = 1'b0, reset_n = 1'b0, zeroize = 1'b0, en = 1'b0;
   logic [AW-1:0] src = '0, dest = '0;
   logic [2:0] np = '0;
   logic mode = 1'b0;
   mem_if_t rd_a, rd_b;
   sig_mem_if_t wr_a, wr_b;
   logic [3:0][23:0] rdat_a, rdat_b;
   logic [3:0][19:0] wdat_a, wdat_b;
   logic busy, done, rerr;
   logic [3:0][23:0] mem [0:DEPTH-1];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sigencode_z_multi dut (
      .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .sigencode_z_enable(en),
      .src_base_addr(src), .dest_base_addr(dest), .num_poly(np), .gamma1_mode(mode),
      .mem_a_rd_req(rd_a), .mem_b_rd_req(rd_b),
      .mem_a_rd_data(rdat_a), .mem_b_rd_data(rdat_b),
      .sigmem_a_wr_req(wr_a), .sigmem_b_wr_req(wr_b),
      .sigmem_a_wr_data(wdat_a), .sigmem_b_wr_data(wdat_b),
      .sigencode_z_busy(busy), .sigencode_z_done(done), .range_err(rerr)
   );

   // Memory returns garbage when not read so the DUT must ignore non-data cycles.
   always @(posedge clk) begin
      rdat_a <= (rd_a.rd_wr_en == RW_READ) ? mem[rd_a.addr] : {$urandom, $urandom, $urandom};
      rdat_b <= (rd_b.rd_wr_en == RW_READ) ? mem[rd_b.addr] : {$urandom, $urandom, $urandom};
   end

   function automatic int unsigned model_z(input int unsigned c, input bit m, inout bit err);
      int unsigned g;
      g = m ? 32'd524288 : 32'd131072;
      if (c <= g) return g - c;
      if (c < Q && c > Q - g) return g + Q - c;
      err = 1'b1;
      return 0;
   endfunction

   function automatic logic [23:0] rand_legal(input bit m);
      int unsigned g;
      g = m ? 32'd524288 : 32'd131072;
      if ($urandom_range(1, 0) == 1) return 24'($urandom_range(g, 0));
      return 24'($urandom_range(Q - 1, Q - g + 1));
   endfunction

   // kind: 0 zero, 1 legal random, 2 mostly legal with raw 24-bit values, 3 fixed lane pattern
   task automatic fill(input int unsigned s, input int words, input bit m, input int kind);
      for (int k = 0; k < words; k++) begin
         for (int i = 0; i < 4; i++) begin
            case (kind)
               0: mem[(s + k) % DEPTH][i] = '0;
               1: mem[(s + k) % DEPTH][i] = rand_legal(m);
               2: mem[(s + k) % DEPTH][i] = ($urandom_range(15, 0) == 0) ? 24'($urandom) : rand_legal(m);
               default: begin
                  case (i)
                     0: mem[(s + k) % DEPTH][i] = 24'd1;
                     1: mem[(s + k) % DEPTH][i] = 24'(Q - 1);
                     2: mem[(s + k) % DEPTH][i] = 24'd131072;
                     default: mem[(s + k) % DEPTH][i] = 24'(Q - 131072 + 1);
                  endcase
               end
            endcase
         end
      end
   endtask

   task automatic run_check(input int unsigned s, input int unsigned d, input int n, input bit m, input int pulse_at);
      int r, last;
      bit legal, exp_err, dummy, eb_busy, eb_done;
      int unsigned w;
      mem_if_t ea, eb;
      sig_mem_if_t wa, wb;
      logic [3:0][19:0] da, db;
      legal   = (n >= 1 && n <= 7);
      r       = legal ? n * 32 : 0;
      exp_err = !legal;
      for (int k = 0; k < 2 * r; k++)
         for (int i = 0; i < 4; i++) void'(model_z(mem[(s + k) % DEPTH][i], m, exp_err));
      @(negedge clk);
      src = AW'(s); dest = AW'(d); np = 3'(n); mode = m; en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0; src = AW'($urandom); dest = AW'($urandom); np = 3'($urandom); mode = 1'($urandom);
      last = legal ? r + 4 : 4;
      for (int t = 1; t <= last; t++) begin
         @(negedge clk);
         en = (t == pulse_at);
         ea = '0; eb = '0; wa = '0; wb = '0; da = '0; db = '0;
         if (t <= r) begin
            w = (s + 2 * (t - 1)) % DEPTH;
            ea.rd_wr_en = RW_READ; ea.addr = AW'(w);
            eb.rd_wr_en = RW_READ; eb.addr = AW'((w + 1) % DEPTH);
         end
         if (t >= 3 && t <= r + 2) begin
            w = (s + 2 * (t - 3)) % DEPTH;
            wa.rd_wr_en = RW_WRITE; wa.addr = AW'((d + 2 * (t - 3)) % DEPTH);
            wb.rd_wr_en = RW_WRITE; wb.addr = AW'((d + 2 * (t - 3) + 1) % DEPTH);
            for (int i = 0; i < 4; i++) begin
               da[i] = 20'(model_z(mem[w][i], m, dummy));
               db[i] = 20'(model_z(mem[(w + 1) % DEPTH][i], m, dummy));
            end
         end
         eb_busy = legal ? (t <= r + 3) : (t == 1);
         eb_done = legal ? (t == r + 3) : (t == 1);
         checks++; if (rd_a !== ea) begin errors++; $display("FAIL rd_a t=%0d got=%h exp=%h", t, rd_a, ea); end
         checks++; if (rd_b !== eb) begin errors++; $display("FAIL rd_b t=%0d got=%h exp=%h", t, rd_b, eb); end
         checks++; if (wr_a !== wa) begin errors++; $display("FAIL wr_a t=%0d got=%h exp=%h", t, wr_a, wa); end
         checks++; if (wr_b !== wb) begin errors++; $display("FAIL wr_b t=%0d got=%h exp=%h", t, wr_b, wb); end
         checks++; if (wdat_a !== da) begin errors++; $display("FAIL wdat_a t=%0d got=%h exp=%h", t, wdat_a, da); end
         checks++; if (wdat_b !== db) begin errors++; $display("FAIL wdat_b t=%0d got=%h exp=%h", t, wdat_b, db); end
         checks++; if (busy !== eb_busy) begin errors++; $display("FAIL busy t=%0d got=%b exp=%b", t, busy, eb_busy); end
         checks++; if (done !== eb_done) begin errors++; $display("FAIL done t=%0d got=%b exp=%b", t, done, eb_done); end
         if (t == 1) begin
            checks++;
            if (rerr !== !legal) begin errors++; $display("FAIL range_err_start got=%b exp=%b", rerr, !legal); end
         end
      end
      checks++;
      if (rerr !== exp_err) begin errors++; $display("FAIL range_err_end got=%b exp=%b", rerr, exp_err); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rd_a !== '0 || rd_b !== '0 || wr_a !== '0 || wr_b !== '0) begin
         errors++; $display("FAIL reset_req got=%h %h %h %h exp=0", rd_a, rd_b, wr_a, wr_b);
      end
      checks++;
      if (wdat_a !== '0 || wdat_b !== '0 || busy !== 1'b0 || done !== 1'b0 || rerr !== 1'b0) begin
         errors++; $display("FAIL reset_out got=%h %h %b%b%b exp=0", wdat_a, wdat_b, busy, done, rerr);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_single_zero();
      fill(32'h40, 64, 1'b1, 0);
      run_check(32'h40, 32'h200, 1, 1'b1, 0);
   endtask

   task automatic test_seven_mode0();
      fill(32'h1000, 448, 1'b0, 3);
      run_check(32'h1000, 32'h3000, 7, 1'b0, 0);
   endtask

   task automatic test_range_err();
      int unsigned s;
      int n;
      s = $urandom_range(20000, 0);
      n = $urandom_range(3, 1);
      fill(s, 2 * n * 32, 1'b1, 1);
      mem[(s + 37) % DEPTH][2] = 24'd524289;
      run_check(s, $urandom_range(DEPTH - 1, 0), n, 1'b1, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (rerr !== 1'b1) begin errors++; $display("FAIL range_err_sticky got=%b exp=1", rerr); end
      fill(s, 64, 1'b1, 1);
      run_check(s, 32'h100, 1, 1'b1, 0);
   endtask

   task automatic test_illegal();
      run_check($urandom_range(DEPTH - 1, 0), $urandom_range(DEPTH - 1, 0), 0, 1'($urandom), 0);
   endtask

   task automatic test_zeroize();
      int unsigned s;
      s = 32'h2000;
      fill(s, 128, 1'b1, 1);
      @(negedge clk);
      src = AW'(s); dest = AW'(32'h5000); np = 3'd2; mode = 1'b1; en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      for (int t = 1; t <= 60; t++) begin
         @(negedge clk);
         if (t == 20) begin
            checks++;
            if (rd_a.rd_wr_en !== RW_READ) begin errors++; $display("FAIL zeroize_pre got=%h exp=READ", rd_a.rd_wr_en); end
            zeroize = 1'b1;
         end else if (t == 21) begin
            zeroize = 1'b0;
            checks++;
            if (rd_a !== '0 || rd_b !== '0 || wr_a !== '0 || wr_b !== '0 || wdat_a !== '0 || wdat_b !== '0 || busy !== 1'b0 || rerr !== 1'b0) begin
               errors++; $display("FAIL zeroize_idle got=%h %h %h %h %b exp=0", rd_a, rd_b, wr_a, wr_b, busy);
            end
         end else if (t > 21) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || rd_a.rd_wr_en !== RW_IDLE || wr_a.rd_wr_en !== RW_IDLE) begin
               errors++; $display("FAIL zeroize_quiet t=%0d got=%b%b exp=00", t, done, busy);
            end
         end
      end
      run_check(s, 32'h6000, 2, 1'b1, 0);
   endtask

   task automatic test_enable_zeroize();
      @(negedge clk);
      np = 3'd1; en = 1'b1; zeroize = 1'b1;
      @(negedge clk);
      en = 1'b0; zeroize = 1'b0;
      for (int t = 0; t < 4; t++) begin
         checks++;
         if (busy !== 1'b0 || rd_a.rd_wr_en !== RW_IDLE) begin
            errors++; $display("FAIL en_zeroize t=%0d got=%b exp=0", t, busy);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      int unsigned s;
      s = $urandom_range(DEPTH - 1, 0);
      fill(s, 64, 1'b0, 1);
      run_check(s, DEPTH - 4, 1, 1'b0, 10);
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 3; j++) begin
         int unsigned s;
         int n;
         bit m;
         s = $urandom_range(DEPTH - 1, 0);
         n = $urandom_range(7, 1);
         m = 1'($urandom);
         fill(s, 2 * n * 32, m, 2);
         run_check(s, $urandom_range(DEPTH - 1, 0), n, m, 0);
      end
   endtask

   initial begin
      test_reset();
      test_single_zero();
      test_seven_mode0();
      test_range_err();
      test_illegal();
      test_zeroize();
      test_enable_zeroize();
      test_wrap();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
